// File: rtl/wavetable_read_arbiter_pkg.sv
// Shared types and sizes for the wavetable read arbiter.
//   N_REQ : number of oscillator cores sharing the table
//   AW/DW : table address / sample widths
//   RL    : memory read latency (mem_rd_en -> mem_rd_data), 1..3
//   IW    : width of a core index / round-robin pointer
package wavetable_read_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned RL    = 1;
  localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IW-1:0] idx_t;

  // One entry of the read-tag pipeline, travelling alongside mem_rd_data.
  typedef struct packed {
    logic            vld;
    logic [IW-1:0]   idx;
  } tag_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Index increment that wraps at N_REQ-1 even when N_REQ is not a power of two.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    return (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
  endfunction

endpackage

// File: rtl/wavetable_read_arbiter_if.sv
// Bundle of oscillator-side, memory-side and status signals of the arbiter.
//   slave  : arbiter view (requests/read data in, memory control/responses out)
//   master : environment view (oscillators + table memory)
interface wavetable_read_arbiter_if;
  import wavetable_read_arbiter_pkg::*;

  logic [N_REQ-1:0]    req_i;
  logic [N_REQ*AW-1:0] req_addr_i;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_rd_data;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [N_REQ-1:0]    overrun;
  logic [N_REQ-1:0]    clr_overrun;
  logic                busy;

  modport slave (
    input  req_i, req_addr_i, mem_rd_data, clr_overrun,
    output mem_rd_en, mem_addr, rsp_valid, rsp_data, overrun, busy
  );

  modport master (
    output req_i, req_addr_i, mem_rd_data, clr_overrun,
    input  mem_rd_en, mem_addr, rsp_valid, rsp_data, overrun, busy
  );

endinterface

// File: rtl/wavetable_read_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set bit of i_pending scanning
// i_rr_ptr, i_rr_ptr+1, ... modulo N_REQ.
//   i_pending     : request vector
//   i_rr_ptr      : highest-priority index this cycle
//   o_grant_valid : any bit of i_pending set
//   o_grant_idx   : selected index (0 when nothing pending)
module wavetable_read_arbiter_rr_priority_select
  import wavetable_read_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_pending,
  input  idx_t             i_rr_ptr,
  output logic             o_grant_valid,
  output idx_t             o_grant_idx
);

  always_comb begin
    int unsigned pos;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    pos           = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = (32'(i_rr_ptr) + i) % N_REQ;
      if (!o_grant_valid && i_pending[IW'(pos)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/wavetable_read_arbiter.sv
// Shares one single-port wavetable among N_REQ oscillator cores: holds one
// pending read per core, issues one round-robin grant per cycle and returns
// samples on a shared bus with a one-hot per-core strobe.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : request / memory / response / status signals (slave view)
module wavetable_read_arbiter
  import wavetable_read_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  wavetable_read_arbiter_if.slave bus
);

  logic [N_REQ-1:0] r_pending;
  logic [AW-1:0]    r_addr_q [N_REQ];
  logic [N_REQ-1:0] r_overrun;
  idx_t             r_rr_ptr;
  logic             r_mem_rd_en;
  logic [AW-1:0]    r_mem_addr;
  tag_t             r_tag [RL+1];
  logic [N_REQ-1:0] r_rsp_valid;
  logic [DW-1:0]    r_rsp_data;

  logic             w_grant_valid;
  idx_t             w_grant_idx;
  logic [N_REQ-1:0] w_grant_oh;
  logic             w_busy;

  wavetable_read_arbiter_rr_priority_select u_select (
    .i_pending     (r_pending),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_grant_oh = w_grant_valid ? onehot(w_grant_idx) : '0;

  // Per-core request capture. A new request always wins over the grant clear,
  // so a re-request in the grant cycle stays pending with its new address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int unsigned k = 0; k < N_REQ; k++) r_addr_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (bus.req_i[k]) begin
          r_pending[k] <= 1'b1;
          r_addr_q[k]  <= bus.req_addr_i[k*AW +: AW];
        end else if (w_grant_oh[k]) begin
          r_pending[k] <= 1'b0;
        end
        // Set beats clear when both happen in the same cycle.
        if (bus.req_i[k] && r_pending[k] && !w_grant_oh[k]) begin
          r_overrun[k] <= 1'b1;
        end else if (bus.clr_overrun[k]) begin
          r_overrun[k] <= 1'b0;
        end
      end
    end
  end

  // Memory read issue and round-robin pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_mem_rd_en <= w_grant_valid;
      if (w_grant_valid) begin
        r_mem_addr <= r_addr_q[w_grant_idx];
        r_rr_ptr   <= wrap_inc(w_grant_idx);
      end
    end
  end

  // Tag pipeline: stage 0 mirrors mem_rd_en, stage RL lines up with mem_rd_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i <= RL; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= tag_t'{vld: w_grant_valid, idx: w_grant_idx};
      for (int unsigned i = 1; i <= RL; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Response register: sample returned data and raise the owner's strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (r_tag[RL].vld) begin
        r_rsp_valid <= onehot(r_tag[RL].idx);
        r_rsp_data  <= bus.mem_rd_data;
      end
    end
  end

  // Busy while anything is pending, in flight, or being returned.
  always_comb begin
    w_busy = (|r_pending) | (|r_rsp_valid);
    for (int unsigned i = 0; i <= RL; i++) w_busy = w_busy | r_tag[i].vld;
  end

  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = w_busy;

endmodule
